// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
// The optional slave-response timeout is enabled with macro WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam int DEF_DW = 32;
  localparam int SW     = DEF_DW / 8;
  localparam int MAX_M  = 8;

  // First requester at or after ptr, wrapping modulo n; returns a one-hot grant.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                               input logic [2:0]       ptr,
                                               input logic [3:0]       n);
    logic [MAX_M-1:0] gnt;
    logic             found;
    logic [3:0]       idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_M; k++) begin
      if (k < int'(n)) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the per-master request/response lanes and the shared slave port.
// Optional feature macro used by the arbiter: WB_ARB_TIMEOUT_EN.
interface wb_rr_arbiter_if #(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SEL_W = DW / 8;

  logic [NUM_M-1:0]       m_cyc_i;
  logic [NUM_M-1:0]       m_stb_i;
  logic [NUM_M-1:0]       m_we_i;
  logic [NUM_M*SEL_W-1:0] m_sel_i;
  logic [NUM_M*AW-1:0]    m_adr_i;
  logic [NUM_M*DW-1:0]    m_dat_i;
  logic [NUM_M-1:0]       m_ack_o;
  logic [NUM_M-1:0]       m_err_o;
  logic [DW-1:0]          m_dat_o;

  logic                   s_cyc_o;
  logic                   s_stb_o;
  logic                   s_we_o;
  logic [SEL_W-1:0]       s_sel_o;
  logic [AW-1:0]          s_adr_o;
  logic [DW-1:0]          s_dat_o;
  logic                   s_ack_i;
  logic [DW-1:0]          s_dat_i;

  // Arbiter view: takes master requests, drives the shared slave port.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i
  );

  // Environment view: the masters plus the downstream slave.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin decision used by the arbiter in IDLE.
// Widths are padded to the package maximum so one pick function serves all NUM_M.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int PW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NUM_M-1:0] gnt
);

  logic [MAX_M-1:0] req_ext;
  logic [MAX_M-1:0] gnt_ext;

  assign req_ext = MAX_M'(req);
  assign gnt_ext = rr_pick(req_ext, 3'(ptr), 4'(NUM_M));
  assign gnt     = gnt_ext[NUM_M-1:0];

  generate
    if (NUM_M < MAX_M) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^gnt_ext[MAX_M-1:NUM_M];
    end
  endgenerate

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_M masters share one slave port.
// Grant is registered and held for the winner's whole cyc; one idle cycle
// separates grants. Define WB_ARB_TIMEOUT_EN to add a slave-response timeout.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_rr_arbiter_if.slave   bus,
  output logic [NUM_M-1:0] grant_o,
  output logic             busy_o
);

  localparam int SEL_W = DW / 8;
  localparam int PW    = $clog2(NUM_M);

  state_t           state_q;
  logic [NUM_M-1:0] grant_q;
  logic             busy_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    g_idx;
  logic [NUM_M-1:0] pick;

  logic             cyc_g;
  logic             stb_g;
  logic             we_g;
  logic [SEL_W-1:0] sel_g;
  logic [AW-1:0]    adr_g;
  logic [DW-1:0]    dat_g;
  logic             to_hit;

  wb_rr_pick #(.NUM_M(NUM_M), .PW(PW)) u_pick (
    .req (bus.m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Select the granted master's request lanes (all zero when nothing is granted).
  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    we_g  = 1'b0;
    sel_g = '0;
    adr_g = '0;
    dat_g = '0;
    g_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        cyc_g = bus.m_cyc_i[i];
        stb_g = bus.m_stb_i[i];
        we_g  = bus.m_we_i[i];
        sel_g = bus.m_sel_i[i*SEL_W +: SEL_W];
        adr_g = bus.m_adr_i[i*AW +: AW];
        dat_g = bus.m_dat_i[i*DW +: DW];
        g_idx = PW'(i);
      end
    end
  end

  assign ptr_nxt = (g_idx == PW'(NUM_M - 1)) ? '0 : g_idx + PW'(1);

  // Arbitration FSM: grant on any cyc in IDLE, release when the winner drops cyc.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.m_cyc_i) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (!cyc_g) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_nxt;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign to_hit = busy_q && (cnt_q == CW'(TIMEOUT));

  // Count stalled strobe cycles; any ack, a timeout or losing the bus restarts it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (!busy_q || !cyc_g || bus.s_ack_i || to_hit) begin
      cnt_q <= '0;
    end else if (stb_g) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // An ack arriving in the timeout cycle still completes the beat, so no error then.
  assign bus.m_err_o = grant_q & {NUM_M{to_hit & ~bus.s_ack_i}};
`else
  localparam int unused_timeout = TIMEOUT;

  assign to_hit      = 1'b0;
  assign bus.m_err_o = '0;
`endif

  assign bus.s_cyc_o = busy_q & cyc_g;
  assign bus.s_stb_o = busy_q & stb_g & ~to_hit;
  assign bus.s_we_o  = busy_q & we_g;
  assign bus.s_sel_o = busy_q ? sel_g : '0;
  assign bus.s_adr_o = busy_q ? adr_g : '0;
  assign bus.s_dat_o = busy_q ? dat_g : '0;

  assign bus.m_ack_o = grant_q & {NUM_M{busy_q & bus.s_ack_i}};
  assign bus.m_dat_o = bus.s_dat_i;

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (two masters, TIMEOUT=4).
// Timeout checks switch on WB_ARB_TIMEOUT_EN to match the build.
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  wb_rr_arbiter_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[i]         = cyc;
    bus.m_stb_i[i]         = stb;
    bus.m_we_i[i]          = we;
    bus.m_sel_i[i*4 +: 4]  = sel;
    bus.m_adr_i[i*32 +: 32] = adr;
    bus.m_dat_i[i*32 +: 32] = dat;
  endtask

  logic [1:0] tie_exp [4];
  int         wins0;
  int         wins1;

  initial begin
    tie_exp[0] = 2'b01;
    tie_exp[1] = 2'b10;
    tie_exp[2] = 2'b01;
    tie_exp[3] = 2'b10;
    wins0 = 0;
    wins1 = 0;

    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;

    // reset holds everything low even with requests pending
    #12;
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_busy",  64'(busy), 64'(1'b0));
    chk("rst_scyc",  64'({bus.s_cyc_o, bus.s_stb_o}), 64'(2'b00));
    chk("rst_ack",   64'(bus.m_ack_o), 64'(2'b00));
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    tick;
    rst = 1'b0;

    // stray ack in IDLE
    bus.s_ack_i = 1'b1;
    settle;
    chk("stray_ack", 64'(bus.m_ack_o), 64'(2'b00));
    tick;
    settle;
    chk("stray_busy", 64'(busy), 64'(1'b0));
    chk("stray_ack2", 64'(bus.m_ack_o), 64'(2'b00));
    bus.s_ack_i = 1'b0;

    // single read from master 1, slave acks in the third cycle
    tick;
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
    settle;
    chk("single_lat", 64'(grant), 64'(2'b00));
    tick;
    settle;
    chk("single_gnt", 64'(grant), 64'(2'b10));
    chk("single_adr", 64'(bus.s_adr_o), 64'(32'h3000_0010));
    chk("single_ctl", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'(3'b110));
    chk("single_wait1", 64'(bus.m_ack_o), 64'(2'b00));
    tick;
    settle;
    chk("single_wait2", 64'(bus.m_ack_o), 64'(2'b00));
    tick;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEAD_BEEF;
    settle;
    chk("single_ack", 64'(bus.m_ack_o), 64'(2'b10));
    chk("single_dat", 64'(bus.m_dat_o), 64'(32'hDEAD_BEEF));
    tick;
    bus.s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("single_ack1cyc", 64'(bus.m_ack_o), 64'(2'b00));
    chk("single_relgnt", 64'(grant), 64'(2'b10));
    tick;
    settle;
    chk("single_idle", 64'({grant, busy}), 64'(3'b000));

    // fairness over four tied rounds after a fresh reset
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 0;
      while (grant == 2'b00 && n < 4) begin
        tick;
        n++;
      end
      settle;
      chk("tie_win", 64'(grant), 64'(tie_exp[r]));
      if (grant == 2'b01) wins0++;
      if (grant == 2'b10) wins1++;
      bus.s_ack_i = 1'b1;
      settle;
      chk("tie_ack", 64'(bus.m_ack_o), 64'(tie_exp[r]));
      tick;
      bus.s_ack_i = 1'b0;
      bus.m_cyc_i = bus.m_cyc_i & ~grant;
      bus.m_stb_i = bus.m_stb_i & ~grant;
      tick;
      settle;
      chk("tie_dead", 64'(grant), 64'(2'b00));
      bus.m_cyc_i = 2'b11;
      bus.m_stb_i = 2'b11;
    end
    chk("tie_fair0", 64'(wins0), 64'(2));
    chk("tie_fair1", 64'(wins1), 64'(2));
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;

    // three-beat write burst from master 0 while master 1 waits
    tick;
    set_m(0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'h1);
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'hAA);
    tick;
    settle;
    chk("burst_gnt", 64'(grant), 64'(2'b01));
    for (int k = 1; k <= 3; k++) begin
      bus.m_dat_i[31:0] = 32'(k);
      bus.s_ack_i = 1'b1;
      settle;
      chk("burst_dat",  64'(bus.s_dat_o), 64'(k));
      chk("burst_ctl",  64'({bus.s_we_o, bus.s_sel_o}), 64'(5'b1_1111));
      chk("burst_ack",  64'(bus.m_ack_o), 64'(2'b01));
      chk("burst_hold", 64'(grant), 64'(2'b01));
      tick;
    end
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    settle;
    chk("burst_rel", 64'(grant), 64'(2'b01));
    chk("burst_m1wait", 64'(bus.m_ack_o), 64'(2'b00));
    tick;
    settle;
    chk("burst_dead", 64'(grant), 64'(2'b00));
    tick;
    settle;
    chk("burst_m1gnt", 64'(grant), 64'(2'b10));
    chk("burst_m1adr", 64'(bus.s_adr_o), 64'(32'h0000_0200));

    // async reset while master 1 owns the bus
    bus.s_ack_i = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_scyc",  64'({bus.s_cyc_o, bus.s_stb_o}), 64'(2'b00));
    chk("arst_grant", 64'(grant), 64'(2'b00));
    chk("arst_busy",  64'(busy), 64'(1'b0));
    chk("arst_ack",   64'(bus.m_ack_o), 64'(2'b00));
    bus.s_ack_i = 1'b0;
    tick;
    rst = 1'b0;
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    tick;
    settle;
    chk("arst_ptr", 64'(grant), 64'(2'b01));
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    tick;
    tick;
    settle;
    chk("arst_idle", 64'(grant), 64'(2'b00));

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: error after four stalled cycles
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    tick;
    settle;
    chk("to_gnt", 64'(grant), 64'(2'b01));
    for (int c = 0; c < 4; c++) begin
      chk("to_stb",   64'(bus.s_stb_o), 64'(1'b1));
      chk("to_noerr", 64'(bus.m_err_o), 64'(2'b00));
      tick;
      settle;
    end
    chk("to_err",  64'(bus.m_err_o), 64'(2'b01));
    chk("to_stb0", 64'(bus.s_stb_o), 64'(1'b0));
    tick;
    settle;
    chk("to_err1cyc", 64'(bus.m_err_o), 64'(2'b00));
    chk("to_stbback", 64'(bus.s_stb_o), 64'(1'b1));
    chk("to_holdgnt", 64'(grant), 64'(2'b01));
    repeat (4) tick;
    bus.s_ack_i = 1'b1;
    settle;
    chk("to_ackwin_err", 64'(bus.m_err_o), 64'(2'b00));
    chk("to_ackwin_ack", 64'(bus.m_ack_o), 64'(2'b01));
    tick;
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
`else
    // without the timeout the arbiter waits indefinitely and never errors
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    tick;
    for (int c = 0; c < 8; c++) begin
      settle;
      chk("noto_err", 64'(bus.m_err_o), 64'(2'b00));
      chk("noto_stb", 64'(bus.s_stb_o), 64'(1'b1));
      tick;
    end
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
`endif
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
